// File: rtl/mdu_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_scheduler_if
// Description : E-stage <-> multiply/divide unit request/response bundle.
//               master : E stage (drives op_valid, op, operands, kill)
//               slave  : MDU scheduler (drives busy, stall, read_data, hi, lo)
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_scheduler_if;
    logic        op_valid;   // E stage holds a valid MDU instruction
    logic [2:0]  op;         // 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MFHI 7 MFLO
    logic [31:0] operand_a;  // rs (forwarded)
    logic [31:0] operand_b;  // rt (forwarded)
    logic        kill;       // abort in-flight op, suppress issue
    logic        busy;       // multiply/divide in flight
    logic        stall;      // freeze F/D/E, bubble M
    logic [31:0] read_data;  // HI for MFHI, LO for MFLO, else 0
    logic [31:0] hi;         // architectural HI
    logic [31:0] lo;         // architectural LO

    modport master (
        output op_valid, op, operand_a, operand_b, kill,
        input  busy, stall, read_data, hi, lo
    );

    modport slave (
        input  op_valid, op, operand_a, operand_b, kill,
        output busy, stall, read_data, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mdu_scheduler
// Description : MIPS multiply/divide scheduler. Owns HI/LO, models a fixed
//               multi-cycle latency for MULT/DIV, raises stall for dependent
//               MDU ops and supports kill of an in-flight operation.
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               mdu      - mdu_scheduler_if.slave request/response bundle
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,   // busy cycles for MULT/MULTU (>= 1)
    parameter int DIV_CYCLES  = 10   // busy cycles for DIV/DIVU   (>= 1)
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mdu_scheduler_if.slave   mdu
);

    localparam int         CNT_W    = 4;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic             pending_skip;  // divide by zero: leave HI/LO untouched

    // ------------------------------------------------------------------
    // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
    // product are then correct for both signed and unsigned forms.
    // ------------------------------------------------------------------
    logic        mult_signed;
    logic [63:0] mult_a_ext;
    logic [63:0] mult_b_ext;
    logic [63:0] product;

    assign mult_signed = (mdu.op == OP_MULT);
    assign mult_a_ext  = mult_signed ? {{32{mdu.operand_a[31]}}, mdu.operand_a}
                                     : {32'd0, mdu.operand_a};
    assign mult_b_ext  = mult_signed ? {{32{mdu.operand_b[31]}}, mdu.operand_b}
                                     : {32'd0, mdu.operand_b};
    assign product     = mult_a_ext * mult_b_ext;

    // ------------------------------------------------------------------
    // Divide on magnitudes, then restore signs. This keeps truncation
    // toward zero explicit and makes 0x80000000 / -1 wrap to 0x80000000
    // instead of relying on signed-overflow behaviour of the operator.
    // ------------------------------------------------------------------
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign div_signed = (mdu.op == OP_DIV);
    assign a_neg      = div_signed & mdu.operand_a[31];
    assign b_neg      = div_signed & mdu.operand_b[31];
    assign b_zero     = (mdu.operand_b == 32'd0);
    assign a_mag      = a_neg ? (32'd0 - mdu.operand_a) : mdu.operand_a;
    assign b_mag      = b_neg ? (32'd0 - mdu.operand_b) : mdu.operand_b;
    assign q_mag      = b_zero ? 32'd0 : (a_mag / b_mag);
    assign r_mag      = b_zero ? 32'd0 : (a_mag % b_mag);
    assign quotient   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign remainder  = a_neg ? (32'd0 - r_mag) : r_mag;

    // ------------------------------------------------------------------
    // Scheduler state machine and HI/LO ownership
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            counter      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            pending_hi   <= '0;
            pending_lo   <= '0;
            pending_skip <= 1'b0;
        end else if (state == RUN) begin
            // kill wins over completion; the pending result is dropped
            if (mdu.kill) begin
                state   <= IDLE;
                counter <= '0;
            end else if (counter == CNT_W'(1)) begin
                state   <= IDLE;
                counter <= '0;
                if (!pending_skip) begin
                    hi_q <= pending_hi;
                    lo_q <= pending_lo;
                end
            end else begin
                counter <= counter - CNT_W'(1);
            end
        end else if (mdu.op_valid && !mdu.kill) begin
            case (mdu.op)
                OP_MULT, OP_MULTU: begin
                    pending_hi   <= product[63:32];
                    pending_lo   <= product[31:0];
                    pending_skip <= 1'b0;
                    counter      <= CNT_W'(MULT_CYCLES);
                    state        <= RUN;
                end
                OP_DIV, OP_DIVU: begin
                    pending_hi   <= remainder;
                    pending_lo   <= quotient;
                    pending_skip <= b_zero;
                    counter      <= CNT_W'(DIV_CYCLES);
                    state        <= RUN;
                end
                OP_MTHI: hi_q <= mdu.operand_a;
                OP_MTLO: lo_q <= mdu.operand_a;
                default: ;  // MFHI/MFLO only read
            endcase
        end
    end

    assign mdu.busy      = (state == RUN);
    assign mdu.stall     = mdu.op_valid & mdu.busy & ~mdu.kill;
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;
    assign mdu.read_data = (mdu.op == OP_MFHI) ? hi_q :
                           (mdu.op == OP_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Multiply/divide unit scheduler for the 5-stage MIPS pipeline; sits beside the E-stage ALU and owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the E stage.
- Models fixed multi-cycle latency for multiply and divide, and raises a stall request while a dependent MDU instruction cannot proceed.
- Supports kill of an in-flight operation on exception/flush.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- op_valid  input  1  E-stage holds a valid MDU instruction this cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MFHI 7=MFLO
- operand_a  input  32  rs value (forwarded)
- operand_b  input  32  rt value (forwarded)
- kill  input  1  abort in-flight op; suppress issue this cycle
- busy  output  1  multiply/divide in flight
- stall  output  1  freeze F/D/E, bubble M
- read_data  output  32  HI (op=6) or LO (op=7), else 0
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, hi=0, lo=0, pending_hi/lo=0. Outputs: busy=0, stall=0, read_data=0.
- States:
  - IDLE, RUN. busy = (state==RUN).
  - counter is 4 bits wide, sized for max(MULT_CYCLES, DIV_CYCLES).
- Issue:
  - Accepted at a rising edge when op_valid=1, busy=0, kill=0.
  - MULT/MULTU (op 0,1):
    - pending = 64-bit signed / unsigned product of operand_a and operand_b.
    - counter <= MULT_CYCLES; state <= RUN.
  - DIV/DIVU (op 2,3):
    - pending_lo = quotient, pending_hi = remainder.
    - Signed division truncates toward zero; remainder takes the dividend's sign.
    - counter <= DIV_CYCLES; state <= RUN.
  - MTHI/MTLO (op 4,5): hi or lo <= operand_a at that edge; no busy period.
  - MFHI/MFLO (op 6,7): read_data combinationally selects hi/lo; no state change.
- Run:
  - Each edge in RUN decrements counter.
  - At the edge where counter==1: hi <= pending_hi, lo <= pending_lo, state <= IDLE.
  - busy is high for exactly N cycles after the issue edge. Results are visible on hi/lo in the first cycle busy=0.
- Divide by zero (operand_b=0): full DIV_CYCLES busy period; hi/lo unchanged at completion.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- stall = op_valid & busy. Applies to any MDU op including MFHI/MFLO/MTHI/MTLO; the op is re-presented and accepted in the first cycle busy=0.
- Completion/issue overlap: an op presented in the last busy cycle stalls that cycle and issues on the next edge. No back-to-back overlap.
- kill:
  - kill=1 in RUN: state <= IDLE, counter <= 0; hi/lo keep their pre-issue values; pending is discarded.
  - kill has priority over completion and over a same-cycle issue.
  - stall is forced to 0 while kill=1.
- read_data ignores busy. The pipeline must honour stall before consuming read_data.
- Reset asserted mid-RUN: immediate return to the reset values; the pending result is lost.

Test Plan:
1. MULT a=0xFFFFFFFF, b=2, then MFLO next cycle -> busy=1 for 5 cycles, stall=1 for 5 cycles, then read_data=0xFFFFFFFE, hi=0xFFFFFFFF.
2. MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
3. Signed division:
   - DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU same operands -> lo=0x7FFFFFFC, hi=1.
4. Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV b=0 -> busy 10 cycles, then hi=0x1234, lo=0x5678.
5. Kill: MULT issued, kill=1 on the 3rd busy cycle -> busy=0 next cycle, hi/lo unchanged. A MTLO presented the same cycle as kill is not accepted.
6. Reset mid-op: reset_n low during DIV run (asynchronous, between edges) -> busy, stall, hi and lo go to 0 immediately. MFHI op=6 after release -> read_data=0, stall=0.
